// File: rtl/fp_add_arb.sv
// Round-robin front end that shares one pipelined fp_add among N_REQ requesters.
// Requester IDs ride an in-order tag FIFO so each adder result returns to its owner.
module fp_add_arb #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   op_a,
  input  logic [32*N_REQ-1:0]   op_b,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic [31:0]           res,
  output logic                  busy,
  output logic                  err,
  output logic                  fpu_start,
  output logic [31:0]           fpu_op_a,
  output logic [31:0]           fpu_op_b,
  input  logic                  fpu_done,
  input  logic [31:0]           fpu_res
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  tag_mem_q [TAG_DEPTH];
  logic [ID_W-1:0]  tag_mem_d [TAG_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             fpu_start_q, fpu_start_d;
  logic [31:0]      fpu_op_a_q, fpu_op_a_d;
  logic [31:0]      fpu_op_b_q, fpu_op_b_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [31:0]      res_q, res_d;
  logic             err_q, err_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W:0]    cand;
  logic             fifo_full, fifo_empty;
  logic             grant_en, push, pop;
  logic [ID_W-1:0]  head_id;

  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head_id    = tag_mem_q[rd_ptr_q[PTR_W-1:0]];

  // Search starts at the round-robin pointer and wraps modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  // Gating with rst_n keeps gnt low while the block is held in reset.
  assign grant_en = rst_n & win_found & ~fifo_full;
  assign push     = grant_en;
  assign pop      = fpu_done & ~fifo_empty;

  always_comb begin
    gnt = '0;
    if (grant_en) gnt[win_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    tag_mem_d   = tag_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    fpu_start_d = 1'b0;
    fpu_op_a_d  = fpu_op_a_q;
    fpu_op_b_d  = fpu_op_b_q;
    done_d      = '0;
    res_d       = res_q;
    err_d       = err_q | (fpu_done & fifo_empty);

    if (push) begin
      tag_mem_d[wr_ptr_q[PTR_W-1:0]] = win_id;
      wr_ptr_d    = wr_ptr_q + (PTR_W+1)'(1);
      rr_ptr_d    = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + ID_W'(1);
      fpu_start_d = 1'b1;
      fpu_op_a_d  = op_a[32*win_id +: 32];
      fpu_op_b_d  = op_b[32*win_id +: 32];
    end

    if (pop) begin
      rd_ptr_d        = rd_ptr_q + (PTR_W+1)'(1);
      done_d[head_id] = 1'b1;
      res_d           = fpu_res;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      fpu_start_q <= 1'b0;
      fpu_op_a_q  <= '0;
      fpu_op_b_q  <= '0;
      done_q      <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      fpu_start_q <= fpu_start_d;
      fpu_op_a_q  <= fpu_op_a_d;
      fpu_op_b_q  <= fpu_op_b_d;
      done_q      <= done_d;
      res_q       <= res_d;
      err_q       <= err_d;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= tag_mem_d[i];
    end
  end

  assign fpu_start = fpu_start_q;
  assign fpu_op_a  = fpu_op_a_q;
  assign fpu_op_b  = fpu_op_b_q;
  assign done      = done_q;
  assign res       = res_q;
  assign err       = err_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_fp_add_arb.sv
// Directed bench for fp_add_arb: a 4-stage stub adder with a sum lookup table,
// plus a scoreboard of expected done/res/cycle entries popped on each done pulse.
module tb_fp_add_arb;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req;
  logic [31:0]   ta [4];
  logic [31:0]   tbv [4];
  logic [127:0]  op_a, op_b;
  logic [3:0]    gnt, done;
  logic [31:0]   res;
  logic          busy, err, fpu_start, fpu_done;
  logic [31:0]   fpu_op_a, fpu_op_b, fpu_res;

  logic          man_mode, man_done;
  logic [31:0]   man_res;
  logic [3:0]    pv;
  logic [31:0]   pd [4];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int t0;

  typedef struct {
    logic [3:0]  done;
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign op_a = {ta[3], ta[2], ta[1], ta[0]};
  assign op_b = {tbv[3], tbv[2], tbv[1], tbv[0]};

  fp_add_arb #(.N_REQ(4), .ID_W(2), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .res(res), .busy(busy), .err(err),
    .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
    .fpu_done(fpu_done), .fpu_res(fpu_res)
  );

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40000000_40000000: return 32'h40800000;
      64'h3F000000_3F000000: return 32'h3F800000;
      default:               return 32'h7FC00000;
    endcase
  endfunction

  // Stub adder: four stages, reset from the same rst_n; manual mode overrides its outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= 4'b0;
      for (int i = 0; i < 4; i++) pd[i] <= 32'h0;
    end else begin
      pv    <= {pv[2:0], fpu_start};
      pd[0] <= fadd(fpu_op_a, fpu_op_b);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
  end
  assign fpu_done = man_mode ? man_done : pv[3];
  assign fpu_res  = man_mode ? man_res  : pd[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ret(input int id, input logic [31:0] r, input int c);
    exp_t e;
    e.done = 4'b0001 << id;
    e.res  = r;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},   {28'h0, gnt},  32'h0);
    chk({tag, "_done"},  {28'h0, done}, 32'h0);
    chk({tag, "_res"},   res,           32'h0);
    chk({tag, "_busy"},  {31'h0, busy}, 32'h0);
    chk({tag, "_err"},   {31'h0, err},  32'h0);
    chk({tag, "_start"}, {31'h0, fpu_start}, 32'h0);
    chk({tag, "_opa"},   fpu_op_a,      32'h0);
    chk({tag, "_opb"},   fpu_op_b,      32'h0);
  endtask

  always @(negedge clk) begin
    if (done !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", {28'h0, done}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_id",  {28'h0, done}, {28'h0, e.done});
        chk("done_res", res, e.res);
        chk("done_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    logic [31:0] t2_exp [4];
    logic [3:0]  m;
    int          id;
    req = 4'b0;
    for (int i = 0; i < 4; i++) begin ta[i] = 32'h0; tbv[i] = 32'h0; end
    man_mode = 1'b0; man_done = 1'b0; man_res = 32'h0;

    #2;
    check_zero("rst");
    step(); step();
    rst_n = 1'b1;

    // Single op: 1.0 + 2.0 from requester 0
    step();
    ta[0] = 32'h3F800000; tbv[0] = 32'h40000000; req = 4'b0001;
    #1;
    chk("t1_gnt", {28'h0, gnt}, 32'h1);
    chk("t1_busy_at_grant", {31'h0, busy}, 32'h0);
    t0 = cyc;
    expect_ret(0, 32'h40400000, t0 + 6);
    step();
    req = 4'b0;
    #1;
    chk("t1_start", {31'h0, fpu_start}, 32'h1);
    chk("t1_opa", fpu_op_a, 32'h3F800000);
    chk("t1_opb", fpu_op_b, 32'h40000000);
    chk("t1_busy_g1", {31'h0, busy}, 32'h1);
    chk("t1_gnt_off", {28'h0, gnt}, 32'h0);
    step();
    chk("t1_start_off", {31'h0, fpu_start}, 32'h0);
    chk("t1_opa_hold", fpu_op_a, 32'h3F800000);
    step(); step(); step();
    chk("t1_busy_g5", {31'h0, busy}, 32'h1);
    step(); step();
    chk("t1_busy_g7", {31'h0, busy}, 32'h0);
    chk("t1_res_hold", res, 32'h40400000);

    // Spurious return with the FIFO empty
    man_mode = 1'b1;
    step();
    man_res = 32'h12345678; man_done = 1'b1;
    step();
    man_done = 1'b0;
    #1;
    chk("sp_done", {28'h0, done}, 32'h0);
    chk("sp_res", res, 32'h40400000);
    chk("sp_err", {31'h0, err}, 32'h1);
    step(); step(); step();
    chk("sp_err_sticky", {31'h0, err}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_zero("sp_rst");
    step();
    rst_n = 1'b1; man_mode = 1'b0;

    // All four requesters at once, each dropping after its grant
    ta[0] = 32'h3F800000; tbv[0] = 32'h40000000;
    ta[1] = 32'h3F800000; tbv[1] = 32'h3F800000;
    ta[2] = 32'h40000000; tbv[2] = 32'h40000000;
    ta[3] = 32'h3F000000; tbv[3] = 32'h3F000000;
    t2_exp[0] = 32'h40400000; t2_exp[1] = 32'h40000000;
    t2_exp[2] = 32'h40800000; t2_exp[3] = 32'h3F800000;
    for (int i = 0; i < 4; i++) begin
      step();
      m = 4'b1111 << i;
      req = m;
      #1;
      chk("t2_gnt", {28'h0, gnt}, {28'h0, 4'b0001 << i});
      expect_ret(i, t2_exp[i], cyc + 6);
    end
    step();
    req = 4'b0;
    for (int i = 0; i < 10; i++) step();

    // Fairness: requesters 0 and 2 held
    ta[2] = 32'h3F000000; tbv[2] = 32'h3F000000;
    for (int i = 0; i < 8; i++) begin
      step();
      req = 4'b0101;
      #1;
      id = (i % 2 == 0) ? 0 : 2;
      chk("t3_gnt", {28'h0, gnt}, {28'h0, 4'b0001 << id});
      expect_ret(id, (id == 0) ? 32'h40400000 : 32'h3F800000, cyc + 6);
    end
    step();
    req = 4'b0;
    for (int i = 0; i < 10; i++) step();

    // Back-pressure: adder never returns, FIFO fills after eight grants
    man_mode = 1'b1; man_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      req = 4'b0001;
      #1;
      chk("t4_gnt", {28'h0, gnt}, (i < 8) ? 32'h1 : 32'h0);
    end
    step();
    man_res = 32'h40A00000; man_done = 1'b1;
    #1;
    chk("t4_gnt_full", {28'h0, gnt}, 32'h0);
    step();
    man_done = 1'b0;
    expect_ret(0, 32'h40A00000, cyc);
    #1;
    chk("t4_gnt_after_pop", {28'h0, gnt}, 32'h1);
    step();
    chk("t4_gnt_full_again", {28'h0, gnt}, 32'h0);
    chk("t4_busy", {31'h0, busy}, 32'h1);
    req = 4'b0;
    rst_n = 1'b0;
    #1;
    check_zero("t4_rst");
    step();
    rst_n = 1'b1; man_mode = 1'b0;

    // Reset mid-flight with three ops outstanding
    step();
    req = 4'b0111;
    #1;
    chk("t5_gnt0", {28'h0, gnt}, 32'h1);
    step();
    req = 4'b0110;
    #1;
    chk("t5_gnt1", {28'h0, gnt}, 32'h2);
    step();
    req = 4'b0100;
    #1;
    chk("t5_gnt2", {28'h0, gnt}, 32'h4);
    step();
    req = 4'b0;
    step();
    req = 4'b1000;
    rst_n = 1'b0;
    #1;
    check_zero("t5_rst");
    step();
    req = 4'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("t5_busy_idle", {31'h0, busy}, 32'h0);
    step();
    req = 4'b0010;
    #1;
    chk("t5_gnt_new", {28'h0, gnt}, 32'h2);
    expect_ret(1, 32'h40000000, cyc + 6);
    step();
    req = 4'b0;
    for (int i = 0; i < 8; i++) step();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_add_arb.md
Name: fp_add_arb

Overview:
- Round-robin arbiter and tag tracker that shares one fully pipelined single-precision fp_add unit among N_REQ requesters.
- Accepts one operation per cycle, registers the operands into the adder, and records the requester ID in an in-order tag FIFO.
- Returns each adder result to the originating requester with a one-cycle done pulse.
- Sits between the FPU clients (core lanes / accelerator ports) and the fp_add instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; equals clog2(N_REQ).
- TAG_DEPTH, 8, tag FIFO entries; power of two, ≥ adder latency + 1 (adder latency is 4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester operation request; held until granted
- op_a  in  32*N_REQ  operand A; requester i at [32*i+31:32*i]
- op_b  in  32*N_REQ  operand B; same packing
- gnt  out  N_REQ  one-hot acceptance, combinational, same cycle as req
- done  out  N_REQ  one-hot result-valid pulse, registered
- res  out  32  result, valid when any done bit is set
- busy  out  1  outstanding count ≠ 0
- err  out  1  sticky: adder done received with the tag FIFO empty
- fpu_start  out  1  to adder start, registered
- fpu_op_a  out  32  to adder op_a, registered
- fpu_op_b  out  32  to adder op_b, registered
- fpu_done  in  1  from adder done
- fpu_res  in  32  from adder res

Behaviour:
- Reset (rst_n low, async):
  - gnt=0, done=0, res=0, busy=0, err=0, fpu_start=0, fpu_op_a=0, fpu_op_b=0.
  - Round-robin pointer=0, FIFO empty, outstanding count=0.
  - Reset mid-operation discards all in-flight tags.
  - The adder is reset from the same source (~rst_n at top level), so no stale fpu_done arrives after reset.
- Arbitration:
  - Search order starts at the pointer and wraps modulo N_REQ.
  - The first asserted req wins; gnt = one-hot of the winner.
  - If the FIFO is full, gnt=0.
  - On a grant, the pointer becomes winner+1, wrapping at N_REQ-1 to 0.
  - With no grant, the pointer holds.
  - A granted requester may present a new operation on the next cycle.
  - At most one grant per cycle.
- Issue:
  - Grant at edge T → fpu_start=1 during cycle T+1, with fpu_op_a/b = the winner's operands.
  - No grant → fpu_start=0; operands hold their last value.
  - Tag (winner ID) is pushed at the same edge.
- Return:
  - When fpu_done=1, pop the FIFO head ID h.
  - At the next edge: done[h]=1 and res=fpu_res.
  - Otherwise done=0 and res holds.
  - End-to-end latency: grant cycle T → done pulse in cycle T+6 (1 issue register + 4 adder stages + 1 return register).
- Simultaneous push and pop: both take effect; the count is unchanged.
- Outstanding count: +1 on push, -1 on pop, range 0..TAG_DEPTH; busy = (count≠0).
- FIFO:
  - Read/write pointers are log2(TAG_DEPTH)+1 bits, wrapping naturally.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Spurious fpu_done while empty: no pop, done stays 0, err set to 1 until reset.
- Results return strictly in issue order; no reordering.

Test Plan:
- Single op: req=0001, op_a=0x3F800000 (1.0), op_b=0x40000000 (2.0) for one cycle.
  - Required: gnt=0001 in that cycle.
  - fpu_start one cycle later.
  - done=0001 and res=0x40400000 (3.0) exactly 6 cycles after the grant.
  - busy high from grant+1 until the done cycle.
- All four requesters assert req=1111 simultaneously with distinct operands, each dropping req after its grant.
  - Required: grants 0001, 0010, 0100, 1000 on four consecutive cycles.
  - done pulses in the same order on four consecutive cycles, each res matching its own operands.
- Fairness: req0 and req2 held high continuously for 8 cycles.
  - Required: grants alternate 0001, 0100, 0001, ….
  - Neither requester is granted twice in a row.
- Back-pressure: adder replaced by a stub holding fpu_done=0; req=0001 held.
  - Required: exactly 8 grants, then gnt=0 while req stays high.
  - A single fpu_done pulse then allows exactly one further grant.
- Spurious return: with the FIFO empty, pulse fpu_done with fpu_res=0x12345678.
  - Required: done stays 0000, res unchanged, err=1 and stays 1 until rst_n low.
- Reset mid-flight: issue 3 ops, assert rst_n low 2 cycles later.
  - Required: all outputs 0 immediately (async).
  - After release: no done pulses, busy=0.
  - A new req=0010 is granted and returns after 6 cycles.
